instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_field_split.sv | 21 ++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM states, the NOP encoding and instruction field positions.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  // Wide enough for a latency counter load of MEM_LATENCY-1 with MEM_LATENCY up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an RV32 instruction word into its decode fields.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  assign opcode_o = instr_i[OPC_LSB +: 7];
  assign funct3_o = instr_i[F3_LSB +: 3];
  assign funct7_o = instr_i[F7_LSB +: 7];
  assign rd_o     = instr_i[RD_LSB +: 5];
  assign rs1_o    = instr_i[RS1_LSB +: 5];
  assign rs2_o    = instr_i[RS2_LSB +: 5];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, fixed-latency imem read, instruction register and field split.
// Define INSTR_FETCH_PERF_EN to add the perf_fetched/perf_stall/perf_redirect counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_1000,
  parameter int unsigned     MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_ren,
  input  logic [31:0]     imem_rdata,
  input  logic            exec_done,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            instr_valid,
  output logic            fault
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_redirect
`endif
);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             fault_q, fault_d;
  logic             capture, accept, misaligned;

  assign capture    = (state_q == WAIT) && (cnt_q == '0);
  assign accept     = (state_q == HOLD) && exec_done;
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (!halt) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (exec_done) state_d = misaligned ? FAULT : FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  // The strobe is gated by rst so it reads low for the whole reset interval.
  always_comb begin
    imem_ren    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH:   imem_ren = !halt && !rst;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (state_q == FETCH && !halt)
      cnt_d = CNT_W'(MEM_LATENCY - 1);
    else if (state_q == WAIT && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
    if (capture)
      instr_d = imem_rdata;
    if (accept) begin
      if (!redirect)       pc_d = pc_q + XLEN'(4);
      else if (!misaligned) pc_d = redirect_pc;
      else                 fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign fault     = fault_q;

  instr_field_split u_split (
    .instr_i  (instr_q),
    .opcode_o (opcode),
    .funct3_o (funct3),
    .funct7_o (funct7),
    .rd_o     (rd),
    .rs1_o    (rs1),
    .rs2_o    (rs2)
  );

`ifdef INSTR_FETCH_PERF_EN
  // Index 0: captures, 1: HOLD cycles without exec_done, 2: accepted redirects.
  logic [2:0] perf_inc;
  assign perf_inc = {accept && redirect && !misaligned,
                     (state_q == HOLD) && !exec_done,
                     capture};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] count_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        count_q <= '0;
      else if (perf_inc[gi] && (count_q != '1))
        count_q <= count_q + 32'd1;
    end
  end

  assign perf_fetched  = g_perf[0].count_q;
  assign perf_stall    = g_perf[1].count_q;
  assign perf_redirect = g_perf[2].count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch at MEM_LATENCY 1 and 3 against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr, pc, instr;
    logic        ren, valid, fault;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, sel;
  logic        exec_done, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] rdata1, rdata3;
  obs_t        o1, o3, o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc, exp_fetched, exp_stall, exp_redir;

  always #5 clk = ~clk;

  // Only the selected instance runs; the other is held in reset.
  assign o = sel ? o3 : o1;

`ifdef INSTR_FETCH_PERF_EN
  logic [2:0][31:0] pf1, pf3, pf;
  assign pf = sel ? pf3 : pf1;
`endif

  instr_fetch #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst | sel), .imem_addr(o1.addr), .imem_ren(o1.ren), .imem_rdata(rdata1),
    .exec_done(exec_done), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .pc(o1.pc), .instr(o1.instr), .opcode(o1.opcode), .funct3(o1.funct3), .funct7(o1.funct7),
    .rd(o1.rd), .rs1(o1.rs1), .rs2(o1.rs2), .instr_valid(o1.valid), .fault(o1.fault)
`ifdef INSTR_FETCH_PERF_EN
    , .perf_fetched(pf1[0]), .perf_stall(pf1[1]), .perf_redirect(pf1[2])
`endif
  );

  instr_fetch #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst | ~sel), .imem_addr(o3.addr), .imem_ren(o3.ren), .imem_rdata(rdata3),
    .exec_done(exec_done), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .pc(o3.pc), .instr(o3.instr), .opcode(o3.opcode), .funct3(o3.funct3), .funct7(o3.funct7),
    .rd(o3.rd), .rs1(o3.rs1), .rs2(o3.rs2), .instr_valid(o3.valid), .fault(o3.fault)
`ifdef INSTR_FETCH_PERF_EN
    , .perf_fetched(pf3[0]), .perf_stall(pf3[1]), .perf_redirect(pf3[2])
`endif
  );

  // Memory image: fixed word at 0x1000, hashed words elsewhere, never NOP or the idle pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0000_1000) return 32'h0000_0537;
    w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    if (w == NOP || w == JUNK) w = w ^ 32'h0000_0100;
    return w;
  endfunction

  // Behavioural memories: data valid exactly L cycles after the read strobe, junk otherwise.
  logic        mv1 = 1'b0;
  logic [31:0] ma1 = '0;
  logic [2:0]  mv3 = '0;
  logic [31:0] ma3 [3];
  always @(posedge clk) begin
    mv1    <= o1.ren;
    ma1    <= o1.addr;
    mv3    <= {mv3[1:0], o3.ren};
    ma3[2] <= ma3[1];
    ma3[1] <= ma3[0];
    ma3[0] <= o3.addr;
  end
  assign rdata1 = mv1    ? mem_word(ma1)    : JUNK;
  assign rdata3 = mv3[2] ? mem_word(ma3[2]) : JUNK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_side();
    exec_done   = 1'($urandom_range(0, 1));
    redirect    = 1'($urandom_range(0, 1));
    redirect_pc = $urandom;
  endtask

  task automatic check_perf();
`ifdef INSTR_FETCH_PERF_EN
    check("perf_fetched", pf[0], exp_fetched);
    check("perf_stall", pf[1], exp_stall);
    check("perf_redirect", pf[2], exp_redir);
`endif
  endtask

  task automatic check_hold(input logic [31:0] w);
    check("hold_valid", 32'(o.valid), 32'd1);
    check("hold_ren", 32'(o.ren), 32'd0);
    check("hold_pc", o.pc, exp_pc);
    check("hold_instr", o.instr, w);
    check("opcode", 32'(o.opcode), 32'(w[6:0]));
    check("rd", 32'(o.rd), 32'(w[11:7]));
    check("funct3", 32'(o.funct3), 32'(w[14:12]));
    check("rs1", 32'(o.rs1), 32'(w[19:15]));
    check("rs2", 32'(o.rs2), 32'(w[24:20]));
    check("funct7", 32'(o.funct7), 32'(w[31:25]));
  endtask

  // One instruction: optional halt cycles, FETCH, lat WAIT cycles, hold_n idle HOLD cycles, exec_done.
  task automatic run_instr(input int lat, input int halt_n, input int hold_n,
                           input logic kind, input logic [31:0] tgt);
    logic [31:0] w;
    w = mem_word(exp_pc);
    for (int k = 0; k < halt_n; k++) begin
      @(negedge clk); halt = 1'b1; rand_side(); #1;
      check("halt_ren", 32'(o.ren), 32'd0);
      check("halt_valid", 32'(o.valid), 32'd0);
    end
    @(negedge clk); halt = 1'b0; rand_side(); #1;
    check("fetch_ren", 32'(o.ren), 32'd1);
    check("fetch_addr", o.addr, exp_pc);
    check("fetch_valid", 32'(o.valid), 32'd0);
    check_perf();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk); halt = 1'($urandom_range(0, 1)); rand_side(); #1;
      check("wait_valid", 32'(o.valid), 32'd0);
      check("wait_ren", 32'(o.ren), 32'd0);
    end
    exp_fetched++;
    for (int k = 0; k < hold_n; k++) begin
      @(negedge clk);
      halt = 1'($urandom_range(0, 1)); exec_done = 1'b0;
      redirect = 1'($urandom_range(0, 1)); redirect_pc = $urandom; #1;
      check_hold(w);
    end
    exp_stall += 32'(hold_n);
    @(negedge clk);
    halt = 1'($urandom_range(0, 1)); exec_done = 1'b1; redirect = kind; redirect_pc = tgt; #1;
    check_hold(w);
    $display("INFO lat=%0d pc=%h instr=%h halt=%0d hold=%0d redirect=%0d target=%h",
             lat, exp_pc, w, halt_n, hold_n, kind, tgt);
    if (!kind) exp_pc = exp_pc + 32'd4;
    else if (tgt[1:0] == 2'b00) begin
      exp_pc = tgt;
      exp_redir++;
    end
  endtask

  task automatic random_instrs(input int lat, input int n);
    logic [31:0] t;
    logic        k;
    for (int i = 0; i < n; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      k = 1'($urandom_range(0, 1));
      run_instr(lat, $urandom_range(0, 2), $urandom_range(0, 3), k, t);
    end
  endtask

  task automatic reset_model();
    exp_pc = RST_PC; exp_fetched = '0; exp_stall = '0; exp_redir = '0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; halt = 1'b0; exec_done = 1'b0; redirect = 1'b0; redirect_pc = '0;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    check("rst_pc", o.pc, RST_PC);
    check("rst_addr", o.addr, RST_PC);
    check("rst_instr", o.instr, NOP);
    check("rst_opcode", 32'(o.opcode), 32'h13);
    check("rst_rd", 32'(o.rd), 32'd0);
    check("rst_valid", 32'(o.valid), 32'd0);
    check("rst_ren", 32'(o.ren), 32'd0);
    check("rst_fault", 32'(o.fault), 32'd0);
    @(posedge clk); #2; rst = 1'b0;

    // MEM_LATENCY = 1
    run_instr(1, 0, 5, 1'b0, 32'h0);
    run_instr(1, 0, 0, 1'b1, 32'h0000_2040);
    run_instr(1, 3, 2, 1'b0, 32'h0);
    random_instrs(1, 16);
    run_instr(1, 0, 1, 1'b1, 32'hFFFF_FFFC);
    run_instr(1, 0, 0, 1'b0, 32'h0);
    run_instr(1, 1, 2, 1'b1, 32'h0000_2042);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); halt = 1'($urandom_range(0, 1)); rand_side(); #1;
      check("fault_flag", 32'(o.fault), 32'd1);
      check("fault_valid", 32'(o.valid), 32'd0);
      check("fault_ren", 32'(o.ren), 32'd0);
      check("fault_pc", o.pc, exp_pc);
    end
    check_perf();

    // MEM_LATENCY = 3
    @(posedge clk); #2; rst = 1'b1; sel = 1'b1; halt = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    @(posedge clk); #2; rst = 1'b0;
    random_instrs(3, 6);

    // Reset in the middle of WAIT: the read still in flight must be dropped.
    @(negedge clk); halt = 1'b0; exec_done = 1'b0; #1;
    check("mid_ren", 32'(o.ren), 32'd1);
    check("mid_addr", o.addr, exp_pc);
    @(negedge clk); #1;
    check("mid_wait_valid", 32'(o.valid), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    check("mid_rst_pc", o.pc, RST_PC);
    check("mid_rst_instr", o.instr, NOP);
    check("mid_rst_valid", 32'(o.valid), 32'd0);
    @(posedge clk); #2; rst = 1'b0; halt = 1'b1;
    reset_model();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); halt = 1'b1; rand_side(); #1;
      check("stale_instr", o.instr, NOP);
      check("stale_valid", 32'(o.valid), 32'd0);
      check("stale_ren", 32'(o.ren), 32'd0);
    end
    run_instr(3, 0, 2, 1'b0, 32'h0);
    run_instr(3, 0, 0, 1'b1, 32'h0000_2040);
    run_instr(3, 0, 1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
